mux_4to1_stream: RTL

Four-channel stream multiplexer with a registered output stage and round-robin arbitration. It merges four valid/ready input channels onto one output channel and tags each beat with its source channel. The tag uses the same 2-bit encoding as the team's `demux_1to4` `sel` input, so a downstream demux can route beats back to the matching lane.

---
 rtl/mux_stream_pkg.sv | 16 +
 rtl/rr_arbiter_4.sv | 33 +++
 rtl/mux_4to1_stream.sv | 90 +++++++++
 3 files changed

// File: rtl/mux_stream_pkg.sv
// Shared definitions for the stream mux and its demux counterpart.
package mux_stream_pkg;

  localparam int CH_NUM = 4;
  localparam int SEL_W  = 2;

  // Channel index. The demux sel input uses the same encoding.
  typedef logic [SEL_W-1:0] ch_idx_t;

  // Output register occupancy.
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

endpackage

// File: rtl/rr_arbiter_4.sv
// Combinational 4-way round-robin arbiter.
// The search starts at ptr and walks upward modulo 4. The first request found wins.
module rr_arbiter_4
  import mux_stream_pkg::*;
(
  input  logic [CH_NUM-1:0] req,
  input  ch_idx_t           ptr,
  output logic [CH_NUM-1:0] gnt_onehot,
  output ch_idx_t           gnt_idx,
  output logic              any
);

  ch_idx_t cand;

  // Priority search from ptr. The 2-bit add wraps 3 -> 0 on its own.
  always_comb begin
    // NOTE: every output of a combinational block gets a default before any
    // conditional assignment, otherwise synthesis infers a latch.
    gnt_onehot = '0;
    gnt_idx    = '0;
    any        = 1'b0;
    cand       = '0;
    for (int k = 0; k < CH_NUM; k++) begin
      cand = ptr + ch_idx_t'(k);
      if (!any && req[cand]) begin
        any     = 1'b1;
        gnt_idx = cand;
      end
    end
    gnt_onehot[gnt_idx] = any;
  end

endmodule

// File: rtl/mux_4to1_stream.sv
// Four-channel valid/ready stream multiplexer.
// The output stage is registered and arbitration is round-robin.
// Each beat is tagged with its source channel on out_sel.
module mux_4to1_stream
  import mux_stream_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [CH_NUM-1:0]        in_valid,
  output logic [CH_NUM-1:0]        in_ready,
  input  logic [CH_NUM*DATA_W-1:0] in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic [SEL_W-1:0]         out_sel
);

  state_e            state_q, state_d;
  ch_idx_t           ptr_q, ptr_d;
  ch_idx_t           sel_q, sel_d;
  logic [DATA_W-1:0] data_q, data_d;

  logic [CH_NUM-1:0] gnt_onehot;
  ch_idx_t           gnt_idx;
  logic              gnt_any;
  logic              load_en;
  logic [DATA_W-1:0] gnt_data;

  rr_arbiter_4 u_arb (
    .req        (in_valid),
    .ptr        (ptr_q),
    .gnt_onehot (gnt_onehot),
    .gnt_idx    (gnt_idx),
    .any        (gnt_any)
  );

  // The output register can take a beat when it is empty or when it is draining this cycle.
  assign out_valid = (state_q == ST_FULL);
  assign load_en   = !out_valid || out_ready;
  assign gnt_data  = in_data[gnt_idx*DATA_W +: DATA_W];
  assign out_data  = data_q;
  assign out_sel   = sel_q;

  // Ready goes only to the granted channel. The rst_n term keeps every handshake closed while reset is held.
  always_comb begin
    in_ready = '0;
    if (load_en && rst_n && gnt_any) begin
      in_ready = gnt_onehot;
    end
  end

  // Next state.
  // A grant always completes a transfer, because the winner's valid is high by construction.
  // The pointer only moves on a transfer.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    data_d  = data_q;
    if (load_en) begin
      if (gnt_any) begin
        state_d = ST_FULL;
        data_d  = gnt_data;
        sel_d   = gnt_idx;
        ptr_d   = gnt_idx + ch_idx_t'(1);
      end else begin
        state_d = ST_EMPTY;
      end
    end
  end

  // State, pointer and output register. Asynchronous reset discards any held beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      ptr_q   <= '0;
      sel_q   <= '0;
      data_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      data_q  <= data_d;
    end
  end

endmodule
